// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// FSM state encoding and the default multi-cycle mul/div latency.
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MD_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int MD_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Load-use hazard comparator: flags when the instruction in ID reads a
// register that the load currently in EX is about to write. r0 never hazards.
module load_use_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              load_use
);

    logic [REG_AW-1:0] eq_rs_bits;
    logic [REG_AW-1:0] eq_rt_bits;

    // Bitwise equality between each ID source index and the EX destination
    generate
        for (genvar gi = 0; gi < REG_AW; gi++) begin : g_cmp
            assign eq_rs_bits[gi] = ~(id_rs[gi] ^ ex_rd[gi]);
            assign eq_rt_bits[gi] = ~(id_rt[gi] ^ ex_rd[gi]);
        end
    endgenerate

    logic rd_nonzero;
    logic rs_hit;
    logic rt_hit;

    // Combine the per-bit matches into the hazard flag
    always_comb begin
        rd_nonzero = |ex_rd;
        rs_hit     = id_use_rs & (&eq_rs_bits);
        rt_hit     = id_use_rt & (&eq_rt_bits);
        load_use   = ex_memread & rd_nonzero & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush/next-PC controller for the 5-stage pipeline. A small FSM
// tracks mul/div and data-memory waits; control outputs are decoded
// combinationally from the current state and this cycle's inputs.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int REG_AW     = 5
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_md_start,
    input  logic              ex_br_taken,
    input  logic [31:0]       ex_br_target,
    input  logic [31:0]       pc_plus4,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic [31:0]       PCOut,
    output logic              stall,
    output logic              flush,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_stall,
    output logic              idex_flush,
    output logic              exmem_stall,
    output logic              md_busy
);

    localparam int CW = $clog2(MD_LATENCY);

    hz_state_t         state_reg;
    hz_state_t         state_next;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     cnt_next;
    logic              load_use;

    // Decoded controls before reset gating
    logic stall_dec;
    logic flush_dec;
    logic ifid_stall_dec;
    logic ifid_flush_dec;
    logic idex_stall_dec;
    logic idex_flush_dec;
    logic exmem_stall_dec;
    logic md_busy_dec;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    // State register and mul/div counter; asynchronous active-low reset
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and control decode; RUN resolves hazards in fixed priority
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        stall_dec       = 1'b0;
        flush_dec       = 1'b0;
        ifid_stall_dec  = 1'b0;
        ifid_flush_dec  = 1'b0;
        idex_stall_dec  = 1'b0;
        idex_flush_dec  = 1'b0;
        exmem_stall_dec = 1'b0;
        md_busy_dec     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    stall_dec       = 1'b1;
                    ifid_stall_dec  = 1'b1;
                    idex_stall_dec  = 1'b1;
                    exmem_stall_dec = 1'b1;
                    state_next      = ST_MEM_WAIT;
                end else if (ex_br_taken) begin
                    // Any mul/div start alongside a taken branch is dropped
                    flush_dec      = 1'b1;
                    ifid_flush_dec = 1'b1;
                    idex_flush_dec = 1'b1;
                end else if (ex_md_start) begin
                    stall_dec      = 1'b1;
                    ifid_stall_dec = 1'b1;
                    idex_stall_dec = 1'b1;
                    cnt_next       = CW'(MD_LATENCY - 2);
                    state_next     = ST_MD_WAIT;
                end else if (load_use) begin
                    // Hold PC and IF/ID, inject one bubble into ID/EX
                    stall_dec      = 1'b1;
                    ifid_stall_dec = 1'b1;
                    idex_flush_dec = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                stall_dec      = 1'b1;
                ifid_stall_dec = 1'b1;
                idex_stall_dec = 1'b1;
                md_busy_dec    = 1'b1;
                if (cnt_reg == '0) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    stall_dec       = 1'b1;
                    ifid_stall_dec  = 1'b1;
                    idex_stall_dec  = 1'b1;
                    exmem_stall_dec = 1'b1;
                end else begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Force all controls low while reset is held; redirect PC on flush
    always_comb begin
        stall       = Reset & stall_dec;
        flush       = Reset & flush_dec;
        ifid_stall  = Reset & ifid_stall_dec;
        ifid_flush  = Reset & ifid_flush_dec;
        idex_stall  = Reset & idex_stall_dec;
        idex_flush  = Reset & idex_flush_dec;
        exmem_stall = Reset & exmem_stall_dec;
        md_busy     = Reset & md_busy_dec;
        PCOut       = flush ? ex_br_target : pc_plus4;
    end

endmodule
